thresh_update_seq: RTL and testbench
====================================

// Module: thresh_update_seq
// PURPOSE
// Single-clock threshold update sequencer. Replaces the fixed 2-lane / 46-beam update FSM in the threshold space.
// On request it streams a banked threshold RAM out to the trigger DSP chain: NLANES lanes per write, configurable data width.
// Adds: absolute/delta subthreshold mode, order-error clamp, padding of unused lanes, abort, and coalesced back-to-back requests.
// PARAMETERS
// NBEAMS       46  number of real beams
// NLANES       2   thresholds written per cycle (lanes per DSP group)
// DWIDTH       18  threshold width, bits
// RAM_LATENCY  2   cycles from ram_en_o/ram_addr_o to valid ram_dat_i (1..4)
// Derived: NGROUPS = ceil(NBEAMS/NLANES); AW = $clog2(2*NGROUPS)
// PORTS
// aclk             in   1              clock
// aresetn          in   1              synchronous active-low reset
// update_req_i     in   1              level; rising edge requests update
// abort_i          in   1              cancel update in progress
// mode_delta_i     in   1              1=subthresh slot gets trig-sub, 0=absolute sub
// ram_en_o         out  1              RAM read enable
// ram_addr_o       out  AW             RAM word address, {group, level}; level 0=trig, 1=sub
// ram_dat_i        in   NLANES*DWIDTH  lane l at [l*DWIDTH +: DWIDTH]
// thresh_o         out  NLANES*DWIDTH  threshold data to DSP chain
// thresh_wr_o      out  NLANES         per-lane write strobe (all bits equal)
// thresh_update_o  out  NLANES         per-lane load/commit pulse (all bits equal)
// busy_o           out  1              update in progress
// done_o           out  1              1-cycle pulse on completed update
// order_err_o      out  1              sticky: some sub > trig in delta mode
// BEHAVIOUR
// Reset (aresetn=0 at a clock edge): FSM IDLE; all outputs 0; pending flag, mode latch and order_err_o cleared. Same mid-update.
// Beam mapping: lane l of group g is beam g*NLANES+l; lanes with index >= NBEAMS are padding.
// States: IDLE, READ (issue), DRAIN (wait for last data/writes), COMMIT.
// Start: update_req_i 0->1 while IDLE = cycle 0. mode_delta_i latched at cycle 0. order_err_o cleared at cycle 0.
// READ: cycles 1..2*NGROUPS, ram_en_o=1.
//   Address order descending, from 2*NGROUPS-1 down to 0: for each group, sub is read before trig.
// Data issued at cycle c is valid at c+RAM_LATENCY; a level-tag shift register of depth RAM_LATENCY tracks it.
// Sub word: registered (no write). Trig word: computes the write pair for that group.
// Writes per group: the subthresh slot one cycle after trig data is valid, then the trig slot on the next cycle.
//   Each write asserts thresh_wr_o = all-ones.
//   Group G-1 writes: sub slot at cycle 3+L, trig slot at cycle 4+L (L=RAM_LATENCY); last trig write at cycle 2*NGROUPS+2+L.
// Subthresh slot value per lane:
//   delta mode: trig-sub computed in DWIDTH+1 bits. If negative, output 0 and set order_err_o.
//   absolute mode: sub.
// Trig slot value per lane: trig.
// Padding lanes: trig slot all-ones, sub slot 0, no order error.
// COMMIT: thresh_update_o all-ones and done_o=1 for exactly one cycle, at cycle 2*NGROUPS+3+L; next state IDLE.
// busy_o=1 from cycle 1 through the COMMIT cycle inclusive.
// thresh_o holds its last value when thresh_wr_o=0.
// Request while busy: sets pending; multiple requests coalesce to one.
//   On COMMIT with pending set, the next update starts with cycle 0 = the cycle after COMMIT; pending is cleared then.
// abort_i while busy: next cycle IDLE, ram_en_o/thresh_wr_o=0, no thresh_update_o, no done_o, pending cleared.
//   Partially written values stay in the DSPs uncommitted. abort_i in IDLE: no effect.
// Simultaneous abort_i and request rising edge: abort wins, and that request is dropped.
// Reads are continuous with no stalls: throughput is one RAM word per cycle.
// TESTING
// Defaults, RAM[2g]=1000+g (trig), RAM[2g+1]=100+g (sub), delta, request -> 46 writes, cycles 5..50.
//   First write sub slot=900 (g=22), next trig=1022; update pulse at cycle 51, done_o once.
// Absolute mode, same data -> first sub-slot write 122; otherwise identical timing.
// Delta mode, sub=500 trig=400 on one lane -> that lane sub slot=0, order_err_o=1 until next start; other lanes unaffected.
// NBEAMS=5, NLANES=2, RAM_LATENCY=3 -> padding lane of group 2 writes sub=0, trig=3FFFF.
//   Last write at cycle 2*3+2+3=11, update at 12.
// Request at cycle 10 of busy update -> second update starts cycle after COMMIT, exactly one extra done_o.
//   abort_i at cycle 20 -> no update pulse.
// aresetn low at cycle 30 -> all outputs 0 next cycle; new request after release runs a full clean update.

Source files
------------

// File: rtl/thresh_update_seq.sv
// thresh_update_seq: streams a banked threshold RAM into the trigger DSP chain,
//   NLANES thresholds per write. Supports delta/absolute subthreshold mode, an order-error
//   clamp, padding of unused lanes, abort, and coalescing of requests that arrive while busy.
// Latency: request edge = cycle 0. Reads run in cycles 1..2*NGROUPS. Writes run in cycles
//   3+L .. 2*NGROUPS+2+L. Commit is at 2*NGROUPS+3+L, where L = RAM_LATENCY.
// Backpressure: none. One RAM word is read per cycle with no stalls, and the DSP chain must
//   accept every write.
// Ports:
//   aclk, aresetn               clock; synchronous active-low reset
//   update_req_i                level; a rising edge requests an update (latched as pending if busy)
//   abort_i                     cancels an update in progress (ignored while idle)
//   mode_delta_i                1: subthresh slot gets trig-sub; 0: subthresh slot gets sub
//   ram_en_o/ram_addr_o         RAM read port; address is {group, level}, level 0=trig, 1=sub
//   ram_dat_i                   RAM data, valid RAM_LATENCY cycles after the read
//   thresh_o/thresh_wr_o        threshold data and per-lane write strobe to the DSP chain
//   thresh_update_o             per-lane commit pulse
//   busy_o, done_o              update in progress; 1-cycle completion pulse
//   order_err_o                 sticky: some sub exceeded trig in delta mode since the last start
module thresh_update_seq #(
  parameter int  NBEAMS      = 46,
  parameter int  NLANES      = 2,
  parameter int  DWIDTH      = 18,
  parameter int  RAM_LATENCY = 2,
  localparam int NGROUPS     = (NBEAMS + NLANES - 1) / NLANES,
  localparam int AW          = (2 * NGROUPS > 1) ? $clog2(2 * NGROUPS) : 1
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     update_req_i,
  input  logic                     abort_i,
  input  logic                     mode_delta_i,
  output logic                     ram_en_o,
  output logic [AW-1:0]            ram_addr_o,
  input  logic [NLANES*DWIDTH-1:0] ram_dat_i,
  output logic [NLANES*DWIDTH-1:0] thresh_o,
  output logic [NLANES-1:0]        thresh_wr_o,
  output logic [NLANES-1:0]        thresh_update_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     order_err_o
);

  localparam int DCW = $clog2(RAM_LATENCY + 2);
  localparam logic [AW-1:0]  LAST_ADDR  = AW'(2 * NGROUPS - 1);
  // The drain lasts RAM_LATENCY+2 cycles: the last trig word lands, then its two writes follow.
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RAM_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                     req_q;
  logic                     req_rise;
  logic                     pend_q;
  logic                     mode_q;
  logic                     err_q;
  logic [AW-1:0]            rd_cnt_q;
  logic [DCW-1:0]           drain_cnt_q;
  logic                     start;
  logic                     flush;
  logic                     commit;

  // Tag pipeline that tracks each outstanding read. The tag is the read address, so the
  // returning word's level (bit 0) and group (upper bits) are known on arrival.
  logic [RAM_LATENCY-1:0]   tag_vld_q;
  logic [AW-1:0]            tag_addr_q [RAM_LATENCY];
  logic                     arr_trig;
  logic                     arr_sub;

  logic [NLANES*DWIDTH-1:0] sub_q;
  logic [NLANES*DWIDTH-1:0] trig_hold_q;
  logic                     trig_pend_q;
  logic [NLANES*DWIDTH-1:0] thresh_q;
  logic [NLANES-1:0]        wr_q;

  logic [NLANES*DWIDTH-1:0] sub_slot;
  logic [NLANES*DWIDTH-1:0] trig_slot;
  logic                     lane_err;

  assign req_rise = update_req_i & ~req_q;
  assign arr_trig = tag_vld_q[RAM_LATENCY-1] & ~tag_addr_q[RAM_LATENCY-1][0];
  assign arr_sub  = tag_vld_q[RAM_LATENCY-1] &  tag_addr_q[RAM_LATENCY-1][0];

  // Next-state logic and outputs derived from the state.
  always_comb begin
    state_d         = state_q;
    start           = 1'b0;
    flush           = 1'b0;
    commit          = 1'b0;
    busy_o          = 1'b0;
    ram_en_o        = 1'b0;
    ram_addr_o      = '0;
    done_o          = 1'b0;
    thresh_update_o = '0;

    case (state_q)
      IDLE: begin
        // A request edge coinciding with abort is dropped. A pending request from the
        // previous update starts here, one cycle after its COMMIT.
        if ((req_rise && !abort_i) || pend_q) begin
          start   = 1'b1;
          state_d = READ;
        end
      end
      READ: begin
        busy_o     = 1'b1;
        ram_en_o   = 1'b1;
        ram_addr_o = rd_cnt_q;
        if (abort_i) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (rd_cnt_q == '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (abort_i) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (drain_cnt_q == DRAIN_LAST) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        busy_o  = 1'b1;
        state_d = IDLE;
        if (abort_i) begin
          flush = 1'b1;
        end else begin
          commit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    done_o          = commit;
    thresh_update_o = {NLANES{commit}};
  end

  // Per-lane slot values for the trig word that is arriving now, paired with the
  // registered sub word of the same group.
  always_comb begin : lane_calc
    int                 grp;
    logic [DWIDTH-1:0]  t;
    logic [DWIDTH-1:0]  s;
    logic [DWIDTH:0]    diff;
    sub_slot  = '0;
    trig_slot = '0;
    lane_err  = 1'b0;
    grp       = int'(tag_addr_q[RAM_LATENCY-1] >> 1);
    for (int l = 0; l < NLANES; l++) begin
      t    = ram_dat_i[l*DWIDTH +: DWIDTH];
      s    = sub_q[l*DWIDTH +: DWIDTH];
      diff = {1'b0, t} - {1'b0, s};
      if (grp * NLANES + l >= NBEAMS) begin
        // Padding lane: trig is parked at the maximum value so it never fires.
        trig_slot[l*DWIDTH +: DWIDTH] = '1;
        sub_slot[l*DWIDTH +: DWIDTH]  = '0;
      end else begin
        trig_slot[l*DWIDTH +: DWIDTH] = t;
        if (!mode_q) begin
          sub_slot[l*DWIDTH +: DWIDTH] = s;
        end else if (diff[DWIDTH]) begin
          // sub > trig: clamp to zero and flag the bad ordering.
          sub_slot[l*DWIDTH +: DWIDTH] = '0;
          lane_err                     = 1'b1;
        end else begin
          sub_slot[l*DWIDTH +: DWIDTH] = diff[DWIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      pend_q      <= 1'b0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_cnt_q    <= '0;
      drain_cnt_q <= '0;
      tag_vld_q   <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) begin
        tag_addr_q[i] <= '0;
      end
      sub_q       <= '0;
      trig_hold_q <= '0;
      trig_pend_q <= 1'b0;
      thresh_q    <= '0;
      wr_q        <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= update_req_i;

      // Requests seen while busy coalesce into a single pending flag.
      if (start || flush) begin
        pend_q <= 1'b0;
      end else if (busy_o && req_rise) begin
        pend_q <= 1'b1;
      end

      if (start) begin
        mode_q   <= mode_delta_i;
        rd_cnt_q <= LAST_ADDR;
      end else if (state_q == READ && rd_cnt_q != '0) begin
        rd_cnt_q <= rd_cnt_q - 1'b1;
      end

      drain_cnt_q <= (state_q == DRAIN) ? drain_cnt_q + 1'b1 : '0;

      tag_vld_q[0]  <= ram_en_o & ~flush;
      tag_addr_q[0] <= ram_addr_o;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        tag_vld_q[i]  <= tag_vld_q[i-1] & ~flush;
        tag_addr_q[i] <= tag_addr_q[i-1];
      end

      if (start) begin
        err_q <= 1'b0;
      end else if (arr_trig && !flush && lane_err) begin
        err_q <= 1'b1;
      end

      if (arr_sub) begin
        sub_q <= ram_dat_i;
      end

      // The subthresh slot goes out the cycle after trig arrives, and the held trig slot
      // the cycle after that. Trig words arrive every other cycle, so the two never collide.
      if (flush) begin
        wr_q        <= '0;
        trig_pend_q <= 1'b0;
      end else if (arr_trig) begin
        thresh_q    <= sub_slot;
        trig_hold_q <= trig_slot;
        trig_pend_q <= 1'b1;
        wr_q        <= '1;
      end else if (trig_pend_q) begin
        thresh_q    <= trig_hold_q;
        trig_pend_q <= 1'b0;
        wr_q        <= '1;
      end else begin
        wr_q <= '0;
      end
    end
  end

  assign thresh_o    = thresh_q;
  assign thresh_wr_o = wr_q;
  assign order_err_o = err_q;

endmodule

// File: tb/tb_thresh_update_seq.sv
// Bench for thresh_update_seq. It uses two instances: the default geometry (a), and
// 5 beams with latency 3 (b). A transaction-level model predicts every output on every
// cycle from the update timeline. Literal checks at key cycles pin the model.
module tb_thresh_update_seq;
  localparam int DW   = 18;
  localparam int NL   = 2;
  localparam int NB_A = 46;
  localparam int L_A  = 2;
  localparam int G_A  = 23;
  localparam int NB_B = 5;
  localparam int L_B  = 3;
  localparam int G_B  = 3;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic aresetn = 1'b0;
  logic req_a = 1'b0, abort_a = 1'b0, mode_a = 1'b1;
  logic req_b = 1'b0, abort_b = 1'b0, mode_b = 1'b1;

  logic          en_a, busy_a, done_a, err_a;
  logic [5:0]    addr_a;
  logic [35:0]   dat_a, thr_a;
  logic [1:0]    wr_a, upd_a;
  logic          en_b, busy_b, done_b, err_b;
  logic [2:0]    addr_b;
  logic [35:0]   dat_b, thr_b;
  logic [1:0]    wr_b, upd_b;

  thresh_update_seq dut_a (
    .aclk(aclk), .aresetn(aresetn), .update_req_i(req_a), .abort_i(abort_a),
    .mode_delta_i(mode_a), .ram_en_o(en_a), .ram_addr_o(addr_a), .ram_dat_i(dat_a),
    .thresh_o(thr_a), .thresh_wr_o(wr_a), .thresh_update_o(upd_a), .busy_o(busy_a),
    .done_o(done_a), .order_err_o(err_a)
  );

  thresh_update_seq #(.NBEAMS(NB_B), .NLANES(NL), .DWIDTH(DW), .RAM_LATENCY(L_B)) dut_b (
    .aclk(aclk), .aresetn(aresetn), .update_req_i(req_b), .abort_i(abort_b),
    .mode_delta_i(mode_b), .ram_en_o(en_b), .ram_addr_o(addr_b), .ram_dat_i(dat_b),
    .thresh_o(thr_b), .thresh_wr_o(wr_b), .thresh_update_o(upd_b), .busy_o(busy_b),
    .done_o(done_b), .order_err_o(err_b)
  );

  // Threshold RAMs with a fixed read latency
  logic [35:0] ram_a [2*G_A];
  logic [35:0] ram_b [2*G_B];
  logic [35:0] pipe_a [L_A];
  logic [35:0] pipe_b [L_B];

  always @(posedge aclk) begin
    pipe_a[0] <= en_a ? ram_a[addr_a] : 36'd0;
    for (int s = 1; s < L_A; s++) pipe_a[s] <= pipe_a[s-1];
    pipe_b[0] <= en_b ? ram_b[addr_b] : 36'd0;
    for (int s = 1; s < L_B; s++) pipe_b[s] <= pipe_b[s-1];
  end
  assign dat_a = pipe_a[L_A-1];
  assign dat_b = pipe_b[L_B-1];

  int done_cnt_a = 0;
  always @(posedge aclk) if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int rel    = 0;

  // Model state: active update, cycle index within it, pending, latched mode,
  // sticky error, previous request level, last written threshold word.
  bit          m_act [2];
  int          m_k [2];
  bit          m_pend [2];
  bit          m_mode [2];
  bit          m_err [2];
  bit          m_prev [2];
  logic [35:0] m_thr [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Word written at cycle k of an update: even offsets carry a group's subthresh slot,
  // odd offsets its trig slot, groups in descending order.
  function automatic logic [35:0] slot_word(input int i, input int G, input int L,
                                            input int nbm, input int k, input bit md,
                                            output bit uf);
    int j, g;
    bit is_sub;
    logic [35:0] tw, sw, w;
    logic [DW-1:0] t, s, v;
    uf     = 1'b0;
    w      = '0;
    j      = k - 3 - L;
    g      = G - 1 - j / 2;
    is_sub = (j % 2 == 0);
    tw     = (i == 0) ? ram_a[2*g]   : ram_b[2*g];
    sw     = (i == 0) ? ram_a[2*g+1] : ram_b[2*g+1];
    for (int l = 0; l < NL; l++) begin
      t = tw[l*DW +: DW];
      s = sw[l*DW +: DW];
      if (g * NL + l >= nbm) v = is_sub ? '0 : '1;
      else if (!is_sub) v = t;
      else if (!md) v = s;
      else if (t >= s) v = t - s;
      else begin v = '0; uf = 1'b1; end
      w[l*DW +: DW] = v;
    end
    return w;
  endfunction

  task automatic model_step(input int i);
    int G, L, nbm, k;
    logic busy, en, done, err;
    logic [5:0] addr;
    logic [1:0] wr, upd;
    logic [35:0] thr;
    bit req, abt, md, act, e_en, e_wr, e_cm, uf, rise;
    string p;
    if (i == 0) begin
      G = G_A; L = L_A; nbm = NB_A; p = "a.";
      busy = busy_a; en = en_a; addr = addr_a; wr = wr_a; upd = upd_a;
      done = done_a; err = err_a; thr = thr_a; req = req_a; abt = abort_a; md = mode_a;
    end else begin
      G = G_B; L = L_B; nbm = NB_B; p = "b.";
      busy = busy_b; en = en_b; addr = {3'b000, addr_b}; wr = wr_b; upd = upd_b;
      done = done_b; err = err_b; thr = thr_b; req = req_b; abt = abort_b; md = mode_b;
    end
    act  = m_act[i];
    k    = m_k[i];
    e_en = act && k <= 2 * G;
    e_wr = act && k >= 3 + L && k <= 2 * G + 2 + L;
    e_cm = act && k == 2 * G + 3 + L && !abt;
    if (e_wr) begin
      m_thr[i] = slot_word(i, G, L, nbm, k, m_mode[i], uf);
      if (uf) m_err[i] = 1'b1;
    end
    chk({p, "busy"}, 64'(busy), 64'(act));
    chk({p, "ram_en"}, 64'(en), 64'(e_en));
    if (e_en) chk({p, "ram_addr"}, 64'(addr), 64'(2 * G - k));
    chk({p, "thresh_wr"}, 64'(wr), e_wr ? 64'd3 : 64'd0);
    chk({p, "thresh"}, 64'(thr), 64'(m_thr[i]));
    chk({p, "update"}, 64'(upd), e_cm ? 64'd3 : 64'd0);
    chk({p, "done"}, 64'(done), 64'(e_cm));
    chk({p, "order_err"}, 64'(err), 64'(m_err[i]));
    // advance to the next cycle
    if (!aresetn) begin
      m_act[i] = 0; m_k[i] = 0; m_pend[i] = 0; m_mode[i] = 0;
      m_err[i] = 0; m_prev[i] = 0; m_thr[i] = '0;
    end else begin
      rise      = req && !m_prev[i];
      m_prev[i] = req;
      if (act) begin
        if (abt) begin
          m_act[i] = 0; m_pend[i] = 0;
        end else begin
          if (rise) m_pend[i] = 1;
          if (k == 2 * G + 3 + L) m_act[i] = 0;
          else m_k[i] = k + 1;
        end
      end else if ((rise && !abt) || m_pend[i]) begin
        m_act[i] = 1; m_k[i] = 1; m_pend[i] = 0; m_mode[i] = md; m_err[i] = 0;
      end
    end
  endtask

  // One clock cycle: model compare mid-cycle, then settle just after the next edge.
  task automatic tick;
    @(negedge aclk);
    if (chk_en) begin
      model_step(0);
      model_step(1);
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic go(input int n);
    repeat (n - rel) tick();
    rel = n;
  endtask

  task automatic start_a;
    req_a = 1'b1;
    rel   = 0;
    go(1);
    req_a = 1'b0;
  endtask

  initial begin
    int base;
    for (int g = 0; g < G_A; g++) begin
      ram_a[2*g]   = {18'(1000 + g), 18'(1000 + g)};
      ram_a[2*g+1] = {18'(100 + g), 18'(100 + g)};
    end
    for (int g = 0; g < G_B; g++) begin
      ram_b[2*g]   = {18'(1000 + g), 18'(1000 + g)};
      ram_b[2*g+1] = {18'(100 + g), 18'(100 + g)};
    end
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_pend[i] = 0; m_mode[i] = 0;
      m_err[i] = 0; m_prev[i] = 0; m_thr[i] = '0;
    end
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    chk_en = 1'b1;
    rel = 0;
    go(2);
    aresetn = 1'b1;
    go(4);
    chk("rst.busy", 64'(busy_a), 64'd0);
    chk("rst.thresh", 64'(thr_a), 64'd0);
    chk("rst.err", 64'(err_a), 64'd0);

    // delta mode, default data
    mode_a = 1'b1;
    start_a();
    chk("t1.addr_first", 64'(addr_a), 64'd45);
    go(4);  chk("t1.no_wr_c4", 64'(wr_a), 64'd0);
    go(5);  chk("t1.sub_l0", 64'(thr_a[17:0]), 64'd900);
            chk("t1.sub_l1", 64'(thr_a[35:18]), 64'd900);
    go(6);  chk("t1.trig_l0", 64'(thr_a[17:0]), 64'd1022);
    go(51); chk("t1.update", 64'(upd_a), 64'd3);
            chk("t1.done", 64'(done_a), 64'd1);
    go(52); chk("t1.idle", 64'(busy_a), 64'd0);
    go(55);

    // absolute mode; mode changes after cycle 0 are ignored
    mode_a = 1'b0;
    start_a();
    mode_a = 1'b1;
    go(5);  chk("t2.sub_abs", 64'(thr_a[17:0]), 64'd122);
    go(51); chk("t2.done", 64'(done_a), 64'd1);
    go(54);

    // order error on lane 0 of group 5
    ram_a[11][17:0] = 18'd500;
    ram_a[10][17:0] = 18'd400;
    start_a();
    go(39); chk("t3.clamp_l0", 64'(thr_a[17:0]), 64'd0);
            chk("t3.other_l1", 64'(thr_a[35:18]), 64'd900);
    go(40); chk("t3.err", 64'(err_a), 64'd1);
    go(60); chk("t3.err_sticky", 64'(err_a), 64'd1);
    ram_a[11] = {18'd105, 18'd105};
    ram_a[10] = {18'd1005, 18'd1005};

    // requests while busy coalesce into one follow-on update
    base = done_cnt_a;
    start_a();
    chk("t4.err_cleared", 64'(err_a), 64'd0);
    go(10); req_a = 1'b1;
    go(11); req_a = 1'b0;
    go(20); req_a = 1'b1;
    go(21); req_a = 1'b0;
    go(51);  chk("t4.done1", 64'(done_a), 64'd1);
    go(52);  chk("t4.gap", 64'(busy_a), 64'd0);
    go(53);  chk("t4.restart", 64'(busy_a), 64'd1);
    go(103); chk("t4.done2", 64'(done_a), 64'd1);
    go(110); chk("t4.done_count", 64'(done_cnt_a - base), 64'd2);

    // abort mid-read
    base = done_cnt_a;
    start_a();
    go(20); abort_a = 1'b1;
    go(21); chk("t5.busy", 64'(busy_a), 64'd0);
            chk("t5.ram_en", 64'(en_a), 64'd0);
            chk("t5.wr", 64'(wr_a), 64'd0);
            abort_a = 1'b0;
    go(60); chk("t5.no_done", 64'(done_cnt_a - base), 64'd0);

    // reset mid-update, then a clean update
    start_a();
    go(30); aresetn = 1'b0;
    go(31); chk("t6.busy", 64'(busy_a), 64'd0);
            chk("t6.thresh", 64'(thr_a), 64'd0);
            chk("t6.wr", 64'(wr_a), 64'd0);
            aresetn = 1'b1;
    go(33);
    start_a();
    go(5);  chk("t6.sub_after", 64'(thr_a[17:0]), 64'd900);
    go(51); chk("t6.done", 64'(done_a), 64'd1);
    go(53);

    // 5 beams, latency 3: padding lane and shortened timeline
    mode_b = 1'b1;
    req_b  = 1'b1;
    rel    = 0;
    go(1);  req_b = 1'b0;
    go(6);  chk("t7.sub_l0", 64'(thr_b[17:0]), 64'd900);
            chk("t7.pad_sub", 64'(thr_b[35:18]), 64'd0);
    go(7);  chk("t7.trig_l0", 64'(thr_b[17:0]), 64'd1002);
            chk("t7.pad_trig", 64'(thr_b[35:18]), 64'h3FFFF);
    go(11); chk("t7.last_wr", 64'(wr_b), 64'd3);
            chk("t7.last_val", 64'(thr_b[17:0]), 64'd1000);
    go(12); chk("t7.wr_end", 64'(wr_b), 64'd0);
            chk("t7.update", 64'(upd_b), 64'd3);
    go(13); chk("t7.idle", 64'(busy_b), 64'd0);
    go(15);

    // abort together with a request edge drops the request; abort while idle does nothing
    req_b = 1'b1; abort_b = 1'b1;
    rel = 0;
    go(1);  abort_b = 1'b0;
            chk("t8.dropped", 64'(busy_b), 64'd0);
    go(2);  req_b = 1'b0;
            chk("t8.still_idle", 64'(busy_b), 64'd0);
    go(4);  abort_b = 1'b1;
    go(5);  abort_b = 1'b0;
            chk("t8.idle_abort", 64'(busy_b), 64'd0);
    go(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
